// File: rtl/mips_ctrl_pkg.sv
// Shared control definitions for the multicycle MIPS-subset core:
// FSM state enum, opcode/funct encodings and ALU operation codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    RTYPEEX,
    RTYPEWB,
    BEQEX,
    ADDIEX,
    ADDIWB,
    JEX,
    ILLEGAL
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/alu_funct_decode.sv
// R-type funct decoder: maps Funct[5:0] to an ALU code.
// Ports: funct in; legal=1 for supported funct, code=ALU op (ADD if not).
module alu_funct_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic       legal,
  output logic [3:0] code
);

  always_comb begin
    legal = 1'b1;
    code  = ALU_ADD;
    unique case (funct)
      FN_ADD:  code = ALU_ADD;
      FN_SUB:  code = ALU_SUB;
      FN_AND:  code = ALU_AND;
      FN_OR:   code = ALU_OR;
      FN_SLT:  code = ALU_SLT;
      FN_NOR:  code = ALU_NOR;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM with retired-instruction counter.
// Ports: Clk/Rst(sync high), Opcode/Funct/Zero in; datapath selects,
// enables, ALUControl, Illegal pulse and InstrCount out.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [5:0]             Opcode,
  input  logic [5:0]             Funct,
  input  logic                   Zero,
  output logic [3:0]             ALUControl,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             PCSrc,
  output logic                   PCWrite,
  output logic                   IorD,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   RegDst,
  output logic                   MemtoReg,
  output logic                   RegWrite,
  output logic                   Illegal,
  output logic [COUNT_WIDTH-1:0] InstrCount
);

  state_t     state;
  state_t     next;
  logic [3:0] functreg;
  logic [3:0] fcode;
  logic       flegal;
  logic       retire;

  alu_funct_decode u_fdec (
    .funct (Funct),
    .legal (flegal),
    .code  (fcode)
  );

  always_ff @(posedge Clk) begin
    if (Rst) state <= FETCH;
    else     state <= next;
  end

  // Funct is only trusted in DECODE; hold its code for RTYPEEX.
  always_ff @(posedge Clk) begin
    if (Rst)                  functreg <= ALU_ADD;
    else if (state == DECODE) functreg <= fcode;
  end

  always_comb begin
    retire = 1'b0;
    unique case (state)
      MEMWB, MEMWR, RTYPEWB,
      BEQEX, ADDIWB, JEX: retire = 1'b1;
      default:            retire = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst)         InstrCount <= '0;
    else if (retire) InstrCount <= InstrCount + COUNT_WIDTH'(1);
  end

  always_comb begin
    next = FETCH;
    unique case (state)
      FETCH:  next = DECODE;
      DECODE: begin
        unique case (Opcode)
          OP_RTYPE: next = flegal ? RTYPEEX : ILLEGAL;
          OP_LW,
          OP_SW:    next = MEMADR;
          OP_BEQ:   next = BEQEX;
          OP_ADDI:  next = ADDIEX;
          OP_J:     next = JEX;
          default:  next = ILLEGAL;
        endcase
      end
      MEMADR:  next = (Opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   next = MEMWB;
      RTYPEEX: next = RTYPEWB;
      ADDIEX:  next = ADDIWB;
      default: next = FETCH;
    endcase
  end

  always_comb begin
    ALUControl = ALU_ADD;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    Illegal    = 1'b0;
    unique case (state)
      FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
      end
      DECODE: ALUSrcB = 2'b11;
      MEMADR, ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: IorD = 1'b1;
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      RTYPEEX: begin
        ALUSrcA    = 1'b1;
        ALUControl = functreg;
      end
      RTYPEWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BEQEX: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        PCWrite    = Zero;
      end
      ADDIWB:  RegWrite = 1'b1;
      JEX: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
      ILLEGAL: Illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction cycle model,
// per-cycle compare of all outputs, plus a 4-bit counter instance.
module tb_multicycle_controller;

  logic       Clk = 0;
  logic       Rst = 1;
  logic [5:0] Opcode = 0;
  logic [5:0] Funct = 0;
  logic       Zero = 0;

  logic [3:0]  alu, alu4;
  logic        sa, sa4;
  logic [1:0]  sb, sb4, ps, ps4;
  logic        pw, io, mw, irw, rd, m2r, rw, il;
  logic        pw4, io4, mw4, irw4, rd4, m2r4, rw4, il4;
  logic [31:0] cnt_o;
  logic [3:0]  cnt4_o;

  int checks = 0;
  int errors = 0;
  int cnt = 0;

  logic        chk = 0;
  logic [16:0] exp_w;
  int          exp_c;
  string       tag = "reset";

  always #5 Clk = ~Clk;

  multicycle_controller #(.COUNT_WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .ALUControl(alu), .ALUSrcA(sa), .ALUSrcB(sb), .PCSrc(ps),
    .PCWrite(pw), .IorD(io), .MemWrite(mw), .IRWrite(irw),
    .RegDst(rd), .MemtoReg(m2r), .RegWrite(rw), .Illegal(il),
    .InstrCount(cnt_o)
  );

  multicycle_controller #(.COUNT_WIDTH(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .ALUControl(alu4), .ALUSrcA(sa4), .ALUSrcB(sb4), .PCSrc(ps4),
    .PCWrite(pw4), .IorD(io4), .MemWrite(mw4), .IRWrite(irw4),
    .RegDst(rd4), .MemtoReg(m2r4), .RegWrite(rw4), .Illegal(il4),
    .InstrCount(cnt4_o)
  );

  wire [16:0] got_w = {alu, sa, sb, ps, pw, io, mw, irw, rd, m2r, rw, il};

  function automatic logic [16:0] mk(
    input logic [3:0] a, input logic xa, input logic [1:0] xb,
    input logic [1:0] p, input logic w, input logic i, input logic m,
    input logic r, input logic d, input logic t, input logic g,
    input logic l);
    return {a, xa, xb, p, w, i, m, r, d, t, g, l};
  endfunction

  function automatic int rcode(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      6'b100111: return 4'b1100;
      default:   return -1;
    endcase
  endfunction

  // 0 = unsupported; otherwise cycles including FETCH
  function automatic int ilen(input logic [5:0] op, input logic [5:0] f);
    case (op)
      6'b100011: return 5;
      6'b101011: return 4;
      6'b001000: return 4;
      6'b000100: return 3;
      6'b000010: return 3;
      6'b000000: return (rcode(f) < 0) ? 0 : 4;
      default:   return 0;
    endcase
  endfunction

  function automatic logic [16:0] model(
    input logic [5:0] op, input logic [5:0] f, input logic z, input int s);
    logic [16:0] adr, ill;
    logic [3:0]  c;
    adr = mk(4'b0010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ill = mk(4'b0010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    c   = 4'(rcode(f));
    if (s == 0) return mk(4'b0010, 0, 2'b01, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    if (s == 1) return mk(4'b0010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    if (ilen(op, f) == 0) return ill;
    case (op)
      6'b100011:
        if (s == 2) return adr;
        else if (s == 3) return mk(4'b0010, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        else return mk(4'b0010, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      6'b101011:
        if (s == 2) return adr;
        else return mk(4'b0010, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      6'b001000:
        if (s == 2) return adr;
        else return mk(4'b0010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      6'b000000:
        if (s == 2) return mk(c, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        else return mk(4'b0010, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
      6'b000100:
        return mk(4'b0110, 1, 0, 2'b01, z, 0, 0, 0, 0, 0, 0, 0);
      default:
        return mk(4'b0010, 0, 0, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0);
    endcase
  endfunction

  always @(negedge Clk) begin
    if (chk) begin
      checks++;
      if (got_w !== exp_w) begin
        errors++;
        $display("FAIL %s ctrl got %b want %b", tag, got_w, exp_w);
      end
      checks++;
      if (cnt_o !== 32'(exp_c)) begin
        errors++;
        $display("FAIL %s count got %0d want %0d", tag, cnt_o, exp_c);
      end
      checks++;
      if (cnt4_o !== 4'(exp_c)) begin
        errors++;
        $display("FAIL %s count4 got %0d want %0d", tag, cnt4_o, 4'(exp_c));
      end
    end
  end

  // Starts #1 after a rising edge with FETCH in progress.
  task automatic instr(input string nm, input logic [5:0] op,
                       input logic [5:0] f, input logic [5:0] flate,
                       input logic z, input int abort);
    int n;
    n = ilen(op, f);
    if (n == 0) n = 3;
    for (int s = 0; s < n; s++) begin
      tag    = $sformatf("%s.%0d", nm, s);
      Opcode = op;
      Funct  = (s <= 1) ? f : flate;
      Zero   = z;
      exp_w  = model(op, f, z, s);
      exp_c  = cnt;
      chk    = 1;
      if (s == abort) Rst = 1;
      @(posedge Clk);
      #1;
      if (s == abort) begin
        Rst = 0;
        cnt = 0;
        return;
      end
    end
    if (ilen(op, f) != 0) cnt++;
  endtask

  task automatic lit(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  initial begin
    Rst = 1;
    @(posedge Clk);
    #1;
    tag   = "reset";
    exp_w = model(0, 0, 0, 0);
    exp_c = 0;
    chk   = 1;
    @(posedge Clk);
    #1;
    Rst = 0;
    lit("reset_irw", int'(irw), 1);
    lit("reset_srcb", int'(sb), 1);

    instr("slt", 6'b000000, 6'b101010, 6'b100100, 0, -1);
    lit("cnt_slt", int'(cnt_o), 1);
    instr("beq1", 6'b000100, 0, 0, 1, -1);
    instr("beq0", 6'b000100, 0, 0, 0, -1);
    lit("cnt_beq", int'(cnt_o), 3);
    instr("lw", 6'b100011, 0, 0, 0, -1);
    instr("sw", 6'b101011, 0, 0, 0, -1);
    instr("badop", 6'b111111, 0, 0, 0, -1);
    instr("badfn", 6'b000000, 6'b000001, 0, 0, -1);
    lit("cnt_ill", int'(cnt_o), 5);
    instr("addi", 6'b001000, 0, 0, 0, -1);
    instr("nor", 6'b000000, 6'b100111, 6'b100000, 0, -1);
    instr("or", 6'b000000, 6'b100101, 0, 0, -1);
    lit("cnt_mid", int'(cnt_o), 8);
    instr("lwrst", 6'b100011, 0, 0, 0, 3);
    lit("cnt_rst", int'(cnt_o), 0);
    for (int k = 0; k < 16; k++) instr("j", 6'b000010, 0, 0, 0, -1);
    lit("cnt_j", int'(cnt_o), 16);
    lit("cnt4_wrap", int'(cnt4_o), 0);
    chk = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
